// File: rtl/jk_arb_pkg.sv
// rtl/jk_arb_pkg.sv - JK command codes, arbiter states and round-robin pick
package jk_arb_pkg;

  localparam logic [1:0] CMD_HOLD   = 2'b00;
  localparam logic [1:0] CMD_CLEAR  = 2'b01;
  localparam logic [1:0] CMD_SET    = 2'b10;
  localparam logic [1:0] CMD_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    APPLY     = 2'd1,
    WAIT_DROP = 2'd2
  } arb_state_t;

  // First requester with req set, searching from ptr+1 around n slots (n <= 8).
  function automatic logic [2:0] rr_next(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int unsigned n);
    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 1; i <= 8; i++) begin
      idx = 3'((32'(ptr) + i) % n);
      if (i <= n && !found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop bit with enable, async reset to 0
module jk_cell
  import jk_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else if (en) begin
      case ({j, k})
        CMD_CLEAR:  q <= 1'b0;
        CMD_SET:    q <= 1'b1;
        CMD_TOGGLE: q <= ~q;
        default:    q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - round-robin owner of a shared JK bank; JK_ARB_LOCK_EN enables lock retain
module jk_bank_arbiter
  import jk_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     cmd,
  input  logic [NREQ*WIDTH-1:0] mask,
  input  logic [NREQ-1:0]       lock,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      q
);

  localparam int PW = $clog2(NREQ);

  arb_state_t       state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    winner;
  logic [PW-1:0]    pick;
  logic [1:0]       lat_cmd;
  logic [WIDTH-1:0] lat_mask;

  assign pick = PW'(rr_next(8'(req), 3'(ptr), NREQ));
  assign busy = (state != IDLE);

`ifndef JK_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= PW'(NREQ - 1);
      winner   <= '0;
      lat_cmd  <= CMD_HOLD;
      lat_mask <= '0;
      gnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            winner   <= pick;
            lat_cmd  <= cmd[2*pick +: 2];
            lat_mask <= mask[WIDTH*pick +: WIDTH];
            state    <= APPLY;
          end
        end
        APPLY: begin
          gnt   <= NREQ'(1) << winner;
          state <= WAIT_DROP;
        end
        WAIT_DROP: begin
          if (!req[winner]) begin
            gnt   <= '0;
            state <= IDLE;
`ifdef JK_ARB_LOCK_EN
            // Parking ptr one behind the winner puts it first in the next search.
            if (lock[winner])
              ptr <= (winner == '0) ? PW'(NREQ - 1) : winner - PW'(1);
            else
              ptr <= winner;
`else
            ptr <= winner;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bank
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .en    ((state == APPLY) && lat_mask[b]),
      .j     (lat_cmd[1]),
      .k     (lat_cmd[0]),
      .q     (q[b])
    );
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb/tb_jk_bank_arbiter.sv - directed self-checking bench for jk_bank_arbiter
module tb_jk_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     cmd;
  logic [NREQ*WIDTH-1:0] mask;
  logic [NREQ-1:0]       lock;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [WIDTH-1:0]      q;

  int n_cmp = 0;
  int n_bad = 0;

  jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .cmd   (cmd),
    .mask  (mask),
    .lock  (lock),
    .gnt   (gnt),
    .busy  (busy),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [NREQ-1:0] exp_g;
    reset = 1'b1; req = '0; cmd = '0; mask = '0; lock = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // requester 0 sets low nibble
    req = 4'b0001; cmd[1:0] = 2'b10; mask[7:0] = 8'h0F;
    tick();
    chk("t1_e0_busy", 32'(busy), 32'h1);
    chk("t1_e0_q", 32'(q), 32'h0);
    chk("t1_e0_gnt", 32'(gnt), 32'h0);
    tick();
    chk("t1_e1_q", 32'(q), 32'h0F);
    chk("t1_e1_gnt", 32'(gnt), 32'h1);
    tick();
    chk("t1_hold_gnt", 32'(gnt), 32'h1);
    chk("t1_hold_busy", 32'(busy), 32'h1);
    req = '0;
    tick();
    chk("t1_rel_gnt", 32'(gnt), 32'h0);
    chk("t1_rel_busy", 32'(busy), 32'h0);
    chk("t1_rel_q", 32'(q), 32'h0F);

    // requester 1 toggles all bits; later cmd/mask changes must be ignored
    req = 4'b0010; cmd[3:2] = 2'b11; mask[15:8] = 8'hFF;
    tick(); tick();
    chk("t2_q", 32'(q), 32'hF0);
    chk("t2_gnt", 32'(gnt), 32'h2);
    cmd[3:2] = 2'b10; mask[15:8] = 8'h0F;
    tick(); tick();
    chk("t6_q_unchanged", 32'(q), 32'hF0);
    req = '0;
    tick();
    chk("t2_rel_gnt", 32'(gnt), 32'h0);
    chk("t6_q_after_rel", 32'(q), 32'hF0);

    // full contention from reset: order 0,1,2,3,0
    reset = 1'b1; tick(); reset = 1'b0;
    cmd = '0; cmd[1:0] = 2'b10; mask = '0; mask[7:0] = 8'h3C;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int t = 0; t < 8 && gnt == '0; t++) tick();
      exp_g = NREQ'(1) << (k % NREQ);
      chk($sformatf("t3_gnt_%0d", k), 32'(gnt), 32'(exp_g));
      chk($sformatf("t3_onehot_%0d", k), 32'($onehot0(gnt)), 32'h1);
      req[k % NREQ] = 1'b0;
      tick();
      chk($sformatf("t3_rel_%0d", k), 32'(gnt), 32'h0);
      req[k % NREQ] = 1'b1;
    end
    req = '0;
    tick(); tick(); tick();
    chk("t3_q", 32'(q), 32'h3C);
    chk("t3_idle", 32'(busy), 32'h0);

    // reset during APPLY discards the command and clears q at once
    cmd[5:4] = 2'b01; mask[23:16] = 8'hFF; req = 4'b0100;
    tick();
    chk("t4_apply_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    chk("t4_async_q", 32'(q), 32'h0);
    chk("t4_async_busy", 32'(busy), 32'h0);
    tick();
    reset = 1'b0; req = '0; cmd[5:4] = 2'b10;
    tick(); tick(); tick();
    chk("t4_q", 32'(q), 32'h0);
    chk("t4_gnt", 32'(gnt), 32'h0);
    chk("t4_busy", 32'(busy), 32'h0);

    // lock retain on release
    cmd = '0; mask = '0; req = 4'b0011; lock = 4'b0001;
    tick(); tick();
    chk("t5_first", 32'(gnt), 32'h1);
    req[0] = 1'b0;
    tick();
    chk("t5_rel", 32'(gnt), 32'h0);
    req[0] = 1'b1;
    tick(); tick();
`ifdef JK_ARB_LOCK_EN
    chk("t5_second", 32'(gnt), 32'h1);
`else
    chk("t5_second", 32'(gnt), 32'h2);
`endif
    req = '0; lock = '0;
    tick(); tick();
    chk("t5_clear", 32'(gnt), 32'h0);

    // req dropped during APPLY: command completes, gnt pulses one cycle
    cmd[7:6] = 2'b10; mask[31:24] = 8'h81; req = 4'b1000;
    tick();
    req = '0;
    tick();
    chk("t7_pulse_gnt", 32'(gnt), 32'h8);
    chk("t7_q", 32'(q), 32'h81);
    tick();
    chk("t7_pulse_end", 32'(gnt), 32'h0);
    chk("t7_busy", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
